// File: rtl/rf_scan_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_scan_arbiter_if
// Groups the signals between the register-file scan arbiter and its
// surroundings: scan control, the CPU side of the shared read port, the
// register-file read port itself, the result stream and status.
//
// Signals (direction as seen from the arbiter, modport slave):
//   start, first_addr, last_addr  in   scan request and inclusive index range
//   abort                         in   terminate the current scan
//   cpu_rd_en, cpu_rd_addr        in   CPU request for the shared read port
//   rf_raddr                      out  shared read-port address
//   rf_rdata                      in   combinational read data
//   cpu_stall                     out  CPU lost the read port this cycle
//   out_valid, out_addr, out_data out  result stream
//   out_ready                     in   result stream back-pressure
//   busy, done                    out  scan in progress / one-cycle completion
// The master modport is the mirror image, used by whatever drives the block.
// ---------------------------------------------------------------------------
interface rf_scan_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) ();
    logic              start;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] last_addr;
    logic              abort;
    logic              cpu_rd_en;
    logic [ADDR_W-1:0] cpu_rd_addr;
    logic [ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              cpu_stall;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              done;

    modport slave (
        input  start, first_addr, last_addr, abort,
        input  cpu_rd_en, cpu_rd_addr, rf_rdata, out_ready,
        output rf_raddr, cpu_stall, out_valid, out_addr, out_data, busy, done
    );

    modport master (
        output start, first_addr, last_addr, abort,
        output cpu_rd_en, cpu_rd_addr, rf_rdata, out_ready,
        input  rf_raddr, cpu_stall, out_valid, out_addr, out_data, busy, done
    );
endinterface

// File: rtl/rf_scan_arbiter.sv
// ---------------------------------------------------------------------------
// rf_scan_arbiter
// Walks an inclusive, wrap-around range of register-file indices and streams
// each (index, data) pair out through a valid/ready port. The register-file
// read port is shared with the CPU: the CPU normally wins, but after
// STARVE_MAX consecutive lost fetch cycles the scanner takes the port and
// stalls the CPU for that one cycle.
//
// Ports:
//   clk    in  single clock, all state on the rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    rf_scan_arbiter_if.slave (scan control, shared read port,
//          result stream, busy/done status)
// ---------------------------------------------------------------------------
module rf_scan_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rf_scan_arbiter_if.slave      bus
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              done_q, done_d;
    logic              grant;

    // The scanner owns the read port only while fetching, and then only if
    // the CPU is idle or has already starved the scanner long enough.
    assign grant = (state_q == FETCH) && (!bus.cpu_rd_en || (starve_q == STARVE_LIM));

    assign bus.rf_raddr  = grant ? cur_q : bus.cpu_rd_addr;
    assign bus.cpu_stall = grant && bus.cpu_rd_en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        last_d      = last_q;
        starve_d    = '0;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cur_d   = bus.first_addr;
                    last_d  = bus.last_addr;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (grant) begin
                    out_data_d  = bus.rf_rdata;
                    out_addr_d  = cur_q;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else if (bus.cpu_rd_en) begin
                    // Cannot pass STARVE_LIM: reaching it forces a grant.
                    starve_d = starve_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (cur_q == last_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // Natural ADDR_W overflow gives the wrap-around scan.
                        cur_d   = cur_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides any handshake or grant taken in the same cycle.
        if (bus.abort) begin
            state_d     = IDLE;
            cur_d       = cur_q;
            last_d      = last_q;
            starve_d    = '0;
            out_valid_d = 1'b0;
            out_addr_d  = out_addr_q;
            out_data_d  = out_data_q;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            last_q      <= '0;
            starve_q    <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            starve_q    <= starve_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end
endmodule

// File: doc/rf_scan_arbiter.md
RF_SCAN_ARBITER -- requirements
Module: rf_scan_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register-index width.
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have parameter STARVE_MAX, default 8, number of consecutive CPU-held cycles before the scanner forces the port.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports start  in  1, first_addr  in  ADDR_W, last_addr  in  ADDR_W: scan request and inclusive index range.
REQ-007 SHALL have port abort  in  1  terminate scan.
REQ-008 SHALL have ports cpu_rd_en  in  1, cpu_rd_addr  in  ADDR_W: CPU use of the shared register-file read port.
REQ-009 SHALL have ports rf_raddr  out  ADDR_W, rf_rdata  in  DATA_W: shared read port, combinational read data.
REQ-010 SHALL have port cpu_stall  out  1  CPU loses the read port this cycle.
REQ-011 SHALL have ports out_valid  out  1, out_ready  in  1, out_addr  out  ADDR_W, out_data  out  DATA_W: result stream.
REQ-012 SHALL have ports busy  out  1, done  out  1 (one-cycle pulse).

Function
REQ-013 SHALL implement states IDLE, FETCH, HOLD; busy=1 in FETCH and HOLD.
REQ-014 IDLE: start=1 SHALL latch first_addr/last_addr, set cur=first_addr, go to FETCH; start outside IDLE is ignored.
REQ-015 grant SHALL be (state==FETCH) && (!cpu_rd_en || starve_cnt==STARVE_MAX).
REQ-016 rf_raddr SHALL be cur when grant, else cpu_rd_addr (combinational).
REQ-017 cpu_stall SHALL be grant && cpu_rd_en (combinational).
REQ-018 starve_cnt SHALL increment in FETCH when cpu_rd_en && !grant, clear on grant or outside FETCH, and never exceed STARVE_MAX.
REQ-019 FETCH with grant SHALL register out_data=rf_rdata, out_addr=cur, out_valid=1 and go to HOLD; read latency is one cycle after grant.
REQ-020 HOLD SHALL keep out_valid, out_addr and out_data stable until out_ready=1.
REQ-021 HOLD with out_ready=1 and cur==last SHALL clear out_valid, pulse done for one cycle, and go to IDLE.
REQ-022 HOLD with out_ready=1 and cur!=last SHALL clear out_valid, set cur=cur+1 modulo 2^ADDR_W, and go to FETCH.
REQ-023 first_addr > last_addr SHALL scan with wrap-around (e.g. 30,31,0,1); first==last SHALL yield exactly one beat.
REQ-024 abort=1 in any state SHALL return to IDLE next cycle with out_valid=0 and no done; abort wins over a simultaneous handshake or grant.
REQ-025 Back-to-back scans SHALL be accepted: start in the cycle after done is honoured.
REQ-026 cpu_rd_en outside FETCH SHALL never be stalled.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, cur=0, starve_cnt=0, out_valid=0, out_addr=0, out_data=0, done=0, busy=0, cpu_stall=0.
REQ-028 Reset asserted mid-scan SHALL discard the scan with no done pulse; after release the block waits for a new start.

Verification
REQ-029 RF x8=1, x9=2; start, first=8, last=9, cpu_rd_en=0, out_ready=1 -> beats (8,1), (9,2), then one done pulse; busy low after.
REQ-030 RF x18..x21=3..6; scan 18..21, out_ready low 3 cycles on each beat -> each beat held stable, order 3,4,5,6, done once.
REQ-031 cpu_rd_en held 1 during scan 20..20, STARVE_MAX=8 -> cpu_stall=1 exactly in the 9th FETCH cycle, rf_raddr=20, beat (20,5).
REQ-032 scan first=30, last=1 -> out_addr sequence 30,31,0,1 with out_data of x0=0.
REQ-033 abort asserted in the cycle out_ready=1 on the first beat of 8..9 -> IDLE next cycle, no done, no second beat.
REQ-034 rst_n pulled low while in HOLD -> out_valid=0 and busy=0 without a clock edge; no done after release.
